// File: rtl/store_buffer_pkg.sv
// Shared memory-stage store constants and store-buffer entry layout.
package store_buffer_pkg;

  localparam int unsigned MEM_STORE_LANES = 4;
  localparam int unsigned MEM_STORE_DATA_W = 32;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_PTR_W = 2;
  localparam int unsigned SB_WADDR_W = 30;
  localparam int unsigned SB_EN_W = MEM_STORE_LANES;
  localparam int unsigned SB_DATA_W = MEM_STORE_DATA_W;

  typedef struct packed {
    logic [SB_WADDR_W-1:0] waddr;
    logic [SB_EN_W-1:0]    en;
    logic [SB_DATA_W-1:0]  data;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_fwd_merge.sv
// Per-lane newest-match search over buffered stores for load forwarding.
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned PTR_W = SB_PTR_W
) (
  input  logic [DEPTH-1:0]      i_valid,
  input  sb_entry_t             i_entries [DEPTH],
  input  logic [PTR_W-1:0]      i_head,
  input  logic [SB_WADDR_W-1:0] i_ld_waddr,
  output logic [SB_EN_W-1:0]    o_fwd_mask,
  output logic [SB_DATA_W-1:0]  o_fwd_data
);

  logic [PTR_W-1:0] w_idx;

  // Walk oldest to newest from head so later matches overwrite earlier ones.
  always_comb begin
    o_fwd_mask = '0;
    o_fwd_data = '0;
    w_idx      = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = i_head + PTR_W'(k);
      if (i_valid[w_idx] && (i_entries[w_idx].waddr == i_ld_waddr)) begin
        for (int unsigned l = 0; l < SB_EN_W; l++) begin
          if (i_entries[w_idx].en[l]) begin
            o_fwd_mask[l]       = 1'b1;
            o_fwd_data[8*l +: 8] = i_entries[w_idx].data[8*l +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Store FIFO between MEM-stage alignment and the data-memory write port.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned PTR_W = SB_PTR_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_we,
  input  logic [31:0] in_addr,
  input  logic [3:0]  in_en,
  input  logic [31:0] in_data,
  output logic        sb_full,
  output logic        sb_empty,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [3:0]  m_en,
  output logic [31:0] m_data,
  input  logic [31:0] ld_addr,
  output logic [3:0]  fwd_mask,
  output logic [31:0] fwd_data
);

  sb_entry_t        r_entries [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W:0]   r_count;

  logic w_push;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_unused_lsbs;

  assign w_unused_lsbs = ^{in_addr[1:0], ld_addr[1:0]};

  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_we & (in_en != 4'b0000) & ~w_full;
  assign w_pop   = ~w_empty & m_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_tail] <= 1'b1;
        r_tail          <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + (PTR_W+1)'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - (PTR_W+1)'(1);
      end
    end
  end

  // Payloads need no reset; visibility is gated by r_valid and r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_entries[r_tail] <= '{waddr: in_addr[31:2], en: in_en, data: in_data};
    end
  end

  assign sb_full  = w_full;
  assign sb_empty = w_empty;
  assign m_valid  = ~w_empty;
  assign m_addr   = w_empty ? 32'h0 : {r_entries[r_head].waddr, 2'b00};
  assign m_en     = w_empty ? 4'h0 : r_entries[r_head].en;
  assign m_data   = w_empty ? 32'h0 : r_entries[r_head].data;

  sb_fwd_merge #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W)
  ) u_fwd_merge (
    .i_valid   (r_valid),
    .i_entries (r_entries),
    .i_head    (r_head),
    .i_ld_waddr(ld_addr[31:2]),
    .o_fwd_mask(fwd_mask),
    .o_fwd_data(fwd_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer against a queue-based reference model.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_we;
  logic [31:0] in_addr;
  logic [3:0]  in_en;
  logic [31:0] in_data;
  logic        sb_full;
  logic        sb_empty;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_addr;
  logic [3:0]  m_en;
  logic [31:0] m_data;
  logic [31:0] ld_addr;
  logic [3:0]  fwd_mask;
  logic [31:0] fwd_data;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  en;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];

  always #5 clk = ~clk;

  store_buffer dut (
    .clk     (clk),
    .reset   (reset),
    .in_we   (in_we),
    .in_addr (in_addr),
    .in_en   (in_en),
    .in_data (in_data),
    .sb_full (sb_full),
    .sb_empty(sb_empty),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_addr  (m_addr),
    .m_en    (m_en),
    .m_data  (m_data),
    .ld_addr (ld_addr),
    .fwd_mask(fwd_mask),
    .fwd_data(fwd_data)
  );

  // Model: a store is visible from the edge after acceptance; the buffer is a plain FIFO.
  task automatic step();
    bit   p;
    bit   o;
    ent_t e;
    p = in_we && (in_en != 4'b0000) && (q.size() < DEPTH);
    o = (q.size() > 0) && m_ready;
    e.addr = {in_addr[31:2], 2'b00};
    e.en   = in_en;
    e.data = in_data;
    @(posedge clk);
    if (o) void'(q.pop_front());
    if (p) q.push_back(e);
    #1;
  endtask

  function automatic void model_fwd(input logic [31:0] la, output logic [3:0] mk,
                                    output logic [31:0] dt);
    mk = '0;
    dt = '0;
    for (int l = 0; l < 4; l++) begin
      for (int j = int'(q.size()) - 1; j >= 0; j--) begin
        if (q[j].addr[31:2] == la[31:2] && q[j].en[l]) begin
          mk[l]        = 1'b1;
          dt[8*l +: 8] = q[j].data[8*l +: 8];
          break;
        end
      end
    end
  endfunction

  task automatic set_store(input logic we, input logic [31:0] a, input logic [3:0] en,
                           input logic [31:0] d);
    in_we   = we;
    in_addr = a;
    in_en   = en;
    in_data = d;
  endtask

  task automatic test_reset();
    tests++;
    if ({sb_empty, sb_full, m_valid, m_addr, m_en, m_data, fwd_mask, fwd_data} !==
        {1'b1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset: empty=%b full=%b mv=%b ma=%h me=%h md=%h fm=%h fd=%h, want 1 0 0 zeros",
               sb_empty, sb_full, m_valid, m_addr, m_en, m_data, fwd_mask, fwd_data);
    end
  endtask

  task automatic test_single();
    m_ready = 1'b0;
    set_store(1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF);
    step();
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      tests++;
      if ({m_valid, m_addr, m_en, m_data} !== {1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF}) begin
        fails++;
        $display("FAIL single_hold[%0d]: mv=%b ma=%h me=%h md=%h, want 1 00000010 f deadbeef",
                 c, m_valid, m_addr, m_en, m_data);
      end
      step();
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    tests++;
    if (sb_empty !== 1'b1 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_drain: empty=%b mv=%b, want 1 0", sb_empty, m_valid);
    end
  endtask

  task automatic test_full();
    logic [31:0] exp_a[$];
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_store(1'b1, 32'h200 + 32'(4 * k), 4'hF, 32'hA000_0000 + 32'(k));
      step();
    end
    tests++;
    if (sb_full !== 1'b1) begin
      fails++;
      $display("FAIL full_flag: got %b want 1", sb_full);
    end
    set_store(1'b1, 32'h210, 4'h3, 32'hA000_0004);
    for (int c = 0; c < 3; c++) step();
    tests++;
    if (sb_full !== 1'b1 || m_addr !== 32'h200) begin
      fails++;
      $display("FAIL full_hold: full=%b ma=%h want 1 00000200", sb_full, m_addr);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    tests++;
    if (sb_full !== 1'b0 || m_addr !== 32'h204) begin
      fails++;
      $display("FAIL full_pop_no_bypass: full=%b ma=%h want 0 00000204", sb_full, m_addr);
    end
    step();
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    tests++;
    if (sb_full !== 1'b1) begin
      fails++;
      $display("FAIL full_fifth_accept: full=%b want 1", sb_full);
    end
    exp_a = '{32'h204, 32'h208, 32'h20C, 32'h210};
    m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (m_valid !== 1'b1 || m_addr !== exp_a[k] || m_data !== 32'hA000_0001 + 32'(k)) begin
        fails++;
        $display("FAIL full_order[%0d]: mv=%b ma=%h md=%h want 1 %h %h", k, m_valid, m_addr,
                 m_data, exp_a[k], 32'hA000_0001 + 32'(k));
      end
      step();
    end
    m_ready = 1'b0;
    tests++;
    if (sb_empty !== 1'b1) begin
      fails++;
      $display("FAIL full_drained: empty=%b want 1", sb_empty);
    end
  endtask

  task automatic test_forward();
    m_ready = 1'b0;
    set_store(1'b1, 32'h20, 4'b0011, 32'h0000_1234);
    step();
    set_store(1'b1, 32'h22, 4'b1100, 32'hAB00_0000);
    step();
    set_store(1'b1, 32'h20, 4'b0001, 32'h0000_0099);
    step();
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    ld_addr = 32'h21;
    #1;
    tests++;
    if (fwd_mask !== 4'hF || fwd_data !== 32'hAB00_1299) begin
      fails++;
      $display("FAIL fwd_merge: mask=%h data=%h want f ab001299", fwd_mask, fwd_data);
    end
    ld_addr = 32'h24;
    #1;
    tests++;
    if (fwd_mask !== 4'h0 || fwd_data !== 32'h0) begin
      fails++;
      $display("FAIL fwd_miss: mask=%h data=%h want 0 00000000", fwd_mask, fwd_data);
    end
    ld_addr = 32'h20;
    m_ready = 1'b1;
    for (int i = 0; i < 8 && q.size() > 0; i++) step();
    m_ready = 1'b0;
    tests++;
    if (sb_empty !== 1'b1 || fwd_mask !== 4'h0) begin
      fails++;
      $display("FAIL fwd_after_drain: empty=%b mask=%h want 1 0", sb_empty, fwd_mask);
    end
  endtask

  task automatic test_back_to_back();
    int ndr = 0;
    bit bad_cnt = 1'b0;
    m_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_store(1'b1, 32'h100 + 32'(4 * k), 4'hF, 32'h5500_0000 + 32'(k));
      if (m_valid) begin
        tests++;
        if (m_addr !== 32'h100 + 32'(4 * ndr)) begin
          fails++;
          $display("FAIL stream_order[%0d]: ma=%h want %h", ndr, m_addr, 32'h100 + 32'(4 * ndr));
        end
        ndr++;
      end
      step();
      if (q.size() > 1 || sb_full === 1'b1) bad_cnt = 1'b1;
    end
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < 8 && m_valid === 1'b1; i++) begin
      tests++;
      if (m_addr !== 32'h100 + 32'(4 * ndr)) begin
        fails++;
        $display("FAIL stream_order[%0d]: ma=%h want %h", ndr, m_addr, 32'h100 + 32'(4 * ndr));
      end
      ndr++;
      step();
    end
    m_ready = 1'b0;
    tests++;
    if (ndr != 20 || bad_cnt || sb_empty !== 1'b1) begin
      fails++;
      $display("FAIL stream_total: drained=%0d overfill=%b empty=%b want 20 0 1", ndr, bad_cnt,
               sb_empty);
    end
  endtask

  task automatic test_zero_en();
    m_ready = 1'b0;
    set_store(1'b1, 32'h300, 4'b0000, 32'hFFFF_FFFF);
    for (int c = 0; c < 3; c++) step();
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    tests++;
    if (sb_empty !== 1'b1 || m_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_en: empty=%b mv=%b want 1 0", sb_empty, m_valid);
    end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_store(1'b1, 32'h400 + 32'(4 * k), 4'hF, 32'h7700_0000 + 32'(k));
      step();
    end
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    ld_addr = 32'h404;
    #2;
    reset = 1'b1;
    #1;
    q.delete();
    tests++;
    if (m_valid !== 1'b0 || sb_full !== 1'b0 || fwd_mask !== 4'h0 || sb_empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid: mv=%b full=%b fm=%h empty=%b want 0 0 0 1", m_valid, sb_full,
               fwd_mask, sb_empty);
    end
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
    set_store(1'b1, 32'h500, 4'h5, 32'h1122_3344);
    step();
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    tests++;
    if ({m_valid, m_addr, m_en, m_data} !== {1'b1, 32'h500, 4'h5, 32'h1122_3344}) begin
      fails++;
      $display("FAIL reset_fresh: mv=%b ma=%h me=%h md=%h want 1 00000500 5 11223344", m_valid,
               m_addr, m_en, m_data);
    end
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    tests++;
    if (sb_empty !== 1'b1) begin
      fails++;
      $display("FAIL reset_fresh_only: empty=%b want 1", sb_empty);
    end
  endtask

  task automatic test_random();
    logic [3:0]  emk;
    logic [31:0] edt;
    logic [31:0] ea;
    logic [3:0]  ee;
    logic [31:0] ed;
    for (int c = 0; c < 400; c++) begin
      set_store(($urandom_range(0, 3) != 0), 32'h40 + 32'($urandom_range(0, 15)),
                ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom), $urandom);
      m_ready = ($urandom_range(0, 2) == 0);
      ld_addr = 32'h40 + 32'($urandom_range(0, 15));
      step();
      model_fwd(ld_addr, emk, edt);
      ea = (q.size() > 0) ? q[0].addr : 32'h0;
      ee = (q.size() > 0) ? q[0].en : 4'h0;
      ed = (q.size() > 0) ? q[0].data : 32'h0;
      tests++;
      if (sb_full !== (q.size() == DEPTH) || sb_empty !== (q.size() == 0) ||
          m_valid !== (q.size() != 0) || m_addr !== ea || m_en !== ee || m_data !== ed) begin
        fails++;
        $display("FAIL rand_fifo[%0d]: full=%b empty=%b mv=%b ma=%h me=%h md=%h want n=%0d %h %h %h",
                 c, sb_full, sb_empty, m_valid, m_addr, m_en, m_data, q.size(), ea, ee, ed);
      end
      tests++;
      if (fwd_mask !== emk || fwd_data !== edt) begin
        fails++;
        $display("FAIL rand_fwd[%0d]: ld=%h mask=%h data=%h want %h %h", c, ld_addr, fwd_mask,
                 fwd_data, emk, edt);
      end
    end
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    m_ready = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    m_ready = 1'b0;
    ld_addr = 32'h0;
    set_store(1'b0, 32'h0, 4'h0, 32'h0);
    #12;
    test_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    test_single();
    test_full();
    test_forward();
    test_back_to_back();
    test_zero_en();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
